// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared defaults and fetch FSM encodings for the instruction fetch controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package imem_fetch_ctrl_pkg;

    localparam int unsigned WIDTH_DEF      = 32;
    localparam int unsigned IMEM_LEN_DEF   = 1024;
    localparam int unsigned RESET_PC_DEF   = 0;
    localparam int unsigned FIFO_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_FETCH = 2'd1,
        FS_FAULT = 2'd2
    } fstate_e;

    // Instructions are 32-bit words; any PC with low bits set cannot be fetched.
    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fetch_fifo.sv
// Prefetch FIFO between the fetch stage and decode; synchronous push/pop/flush.
// Latency: a pushed entry is at the head the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; flush wins over push.
module fetch_fifo #(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so equal indices can mean either full or empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values; a flush empties the FIFO regardless of push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers, cleared asynchronously so nothing survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, reads imem, queues {inst, pc} for decode.
// Latency: first instruction valid 2 cycles after reset release; 1 instr/cycle steady state.
// Backpressure: fetch stalls while the prefetch FIFO is full and decode is not popping.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned IMEM_LEN   = IMEM_LEN_DEF,
    parameter int unsigned RESET_PC   = RESET_PC_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-3:0] imem_add,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             fault,
    output logic [WIDTH-1:0] fault_pc
);
    localparam logic [WIDTH-1:0] IMEM_LEN_W = WIDTH'(IMEM_LEN);
    localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

    fstate_e          state_q, state_d;
    logic [WIDTH-1:0] fpc_q, fpc_d;
    logic             fault_q, fault_d;
    logic [WIDTH-1:0] fault_pc_q, fault_pc_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] fifo_head;
    logic               fifo_push;
    logic               fifo_flush;
    logic               pop;
    logic               fire;

    assign imem_add   = fpc_q[WIDTH-1:2];
    assign inst_valid = !fifo_empty;
    assign inst       = fifo_head[2*WIDTH-1:WIDTH];
    assign inst_pc    = fifo_head[WIDTH-1:0];
    assign fault      = fault_q;
    assign fault_pc   = fault_pc_q;

    assign pop  = inst_valid && inst_ready;
    // A slot frees up this cycle either because the FIFO has room or decode is taking the head.
    assign fire = (state_q == FS_FETCH) && (!fifo_full || pop);

    // Next-state: redirect beats everything; a BOOT-cycle redirect lands on the BOOT->FETCH edge.
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        if (redirect_valid) begin
            fifo_flush = 1'b1;
            if (word_aligned(redirect_pc[1:0])) begin
                fpc_d   = redirect_pc;
                fault_d = 1'b0;
                state_d = FS_FETCH;
            end else begin
                fault_pc_d = redirect_pc;
                fault_d    = 1'b1;
                state_d    = FS_FAULT;
            end
        end else begin
            case (state_q)
                FS_BOOT: begin
                    state_d = FS_FETCH;
                end
                FS_FETCH: begin
                    if (fire) begin
                        if (fpc_q < IMEM_LEN_W) begin
                            fifo_push = 1'b1;
                            fpc_d     = fpc_q + PC_STEP;
                        end else begin
                            fault_pc_d = fpc_q;
                            fault_d    = 1'b1;
                            state_d    = FS_FAULT;
                        end
                    end
                end
                FS_FAULT: begin
                    state_d = FS_FAULT;
                end
                default: begin
                    state_d = FS_BOOT;
                end
            endcase
        end
    end

    // FSM, fetch PC and registered fault outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_BOOT;
            fpc_q      <= RESET_PC_W;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat ({imem_data, fpc_q}),
        .pop      (pop),
        .flush    (fifo_flush),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction fetch controller for the instruction memory.
- Owns the fetch PC and drives the word address into the combinational-read instruction memory.
- Captures returned words into a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Handles PC redirects (branch/jump/exception) with flush, and flags misaligned or out-of-range fetches.

Parameters:
- WIDTH, 32, data/address width (matches `WIDTH`).
- IMEM_LEN, 1024, instruction memory size in bytes (matches `IMEM_LEN`); fetch addresses >= IMEM_LEN fault.
- RESET_PC, 0, fetch PC after reset; must be word aligned.
- FIFO_DEPTH, 2, prefetch entries; power of 2, >= 2.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- imem_add, out, WIDTH-2: word address to instruction memory (fetch PC[WIDTH-1:2]).
- imem_data, in, WIDTH: instruction word, valid combinationally in the same cycle as imem_add.
- redirect_valid, in, 1: load new fetch PC.
- redirect_pc, in, WIDTH: new byte PC.
- inst_valid, out, 1: head-of-FIFO instruction valid.
- inst_ready, in, 1: decode accepts the head.
- inst, out, WIDTH: instruction word at head.
- inst_pc, out, WIDTH: byte PC of inst.
- fault, out, 1: fetch fault (sticky until redirect).
- fault_pc, out, WIDTH: offending PC.

Behaviour:
Reset values (async on rst_n low):
- State = BOOT, fpc = RESET_PC, FIFO empty.
- inst_valid = 0, fault = 0, fault_pc = 0, imem_add = RESET_PC>>2.

States:
- BOOT: one idle cycle after reset release while instruction memory contents settle. No fetch. Always -> FETCH.
- FETCH: drive imem_add = fpc[WIDTH-1:2] every cycle.
  - Fetch fires when the FIFO has space, or is full with a pop this cycle.
  - On a firing edge: push {imem_data, fpc}, then fpc += 4.
  - If fpc >= IMEM_LEN at the firing point: no push, fault_pc = fpc, -> FAULT.
- FAULT: no fetch. fault = 1. FIFO still drains to decode. Leaves only on redirect.

Handshake:
- inst_valid = FIFO not empty. inst/inst_pc = head entry, held stable while inst_valid && !inst_ready.
- Pop on inst_valid && inst_ready.
- Push and pop in the same cycle are allowed at any occupancy, including full.

Latency:
- First inst_valid is asserted 2 cycles after the first rising edge with rst_n high (BOOT, then first fetch).
- Steady state: 1 instruction per cycle while inst_ready = 1.

Redirect (highest priority, any state except BOOT):
- Flush FIFO; an in-flight pop that cycle still counts as accepted.
- Suppress that cycle's push.
- fpc <= redirect_pc; fault cleared; -> FETCH.
- If redirect_pc[1:0] != 0: fpc is not updated, fault_pc = redirect_pc, -> FAULT.
- inst_valid = 0 in the cycle after a redirect. The first redirected instruction is valid 1 cycle later.
- A redirect during BOOT is held and applied on the BOOT -> FETCH transition.

Arithmetic:
- fpc increments modulo 2^WIDTH. The range check catches wrap before it matters.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty are distinguished by the MSB.

Mid-operation reset:
- Immediately clears FIFO and fault, and returns to BOOT. No partial entry survives.

Decomposition:
- Shared include holds: WIDTH, IMEM_LEN, RESET_PC defaults, state encodings (FS_BOOT, FS_FETCH, FS_FAULT).
- One natural sub-module: fetch_fifo. Synchronous FIFO with push/pop/flush, width 2*WIDTH, depth FIFO_DEPTH. Exposes full, empty, head.
- The FSM and PC logic stay in imem_fetch_ctrl.

Test Plan:
- Reset release, memory words 0x11111111, 0x22222222, 0x33333333 at 0x0/0x4/0x8, inst_ready = 1 -> inst_valid rises in the 2nd cycle. inst/inst_pc stream (0x11111111, 0x0), (0x22222222, 0x4), (0x33333333, 0x8) on consecutive cycles.
- inst_ready = 0 for 5 cycles after the first valid -> FIFO fills to 2 and imem_add stops advancing at word 2. inst holds 0x11111111. On release, PCs 0x0, 0x4, 0x8 arrive in order, with no loss or duplication.
- Redirect to 0x20 while the FIFO holds 0x4 and 0x8 -> the next cycle inst_valid = 0. The following cycle inst_pc = 0x20; 0x4/0x8 are never presented.
- Redirect to 0x22 -> fault = 1, fault_pc = 0x22, no further fetch. A redirect to 0x40 clears fault, and inst_pc = 0x40 follows.
- Sequential fetch with IMEM_LEN = 16 -> PCs 0x0 to 0xC delivered, then fault = 1 with fault_pc = 0x10, and the FIFO drains normally.
- rst_n pulsed low while the FIFO is full and fault = 0 -> inst_valid drops asynchronously. After release, fetch restarts at RESET_PC with BOOT latency.
